// File: rtl/wrr_pkg.sv
// Shared types, default sizing and a reference pick helper for the
// weighted round-robin arbiter.
package wrr_pkg;

  localparam int WRR_N_REQ = 4;
  localparam int WRR_WW    = 6;
  localparam int WRR_DEF_W = 1;
  localparam int WRR_IW    = (WRR_N_REQ > 1) ? $clog2(WRR_N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    RELOAD = 2'd2
  } wrr_state_e;

  typedef bit [WRR_WW-1:0] weight_t;

  // First set index of mask at or after start, wrapping past the top.
  function automatic logic [WRR_IW-1:0] rr_pick(input logic [WRR_N_REQ-1:0] mask,
                                                input logic [WRR_IW-1:0]    start);
    logic [WRR_IW-1:0] idx;
    logic [WRR_IW-1:0] pos;
    logic              found;
    idx   = {WRR_IW{1'b0}};
    found = 1'b0;
    for (int k = 0; k < WRR_N_REQ; k++) begin
      pos = WRR_IW'((int'(start) + k) % WRR_N_REQ);
      if (!found && mask[pos]) begin
        found = 1'b1;
        idx   = pos;
      end else begin
        found = found;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/wrr_arbiter_rr_pick_first.sv
// Rotating priority picker: rotate the mask so 'start' sits at bit 0,
// take the lowest set bit, then rotate the result back.
module rr_pick_first #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_mask,
  input  logic [IW-1:0] i_start,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);

  localparam logic [IW:0] NV = (IW+1)'(N);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [IW-1:0]  w_off;
  logic [IW:0]    w_sum;

  // Rotate, priority-encode the lowest set bit, and map back to an absolute index.
  always_comb begin
    w_dbl    = {i_mask, i_mask} >> i_start;
    w_rot    = w_dbl[N-1:0];
    w_off    = {IW{1'b0}};
    o_found  = |w_rot;
    for (int j = N - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_off = IW'(j);
      end else begin
        w_off = w_off;
      end
    end
    w_sum = {1'b0, i_start} + {1'b0, w_off};
    if (w_sum >= NV) begin
      o_idx = IW'(w_sum - NV);
    end else begin
      o_idx = w_sum[IW-1:0];
    end
    o_onehot        = {N{1'b0}};
    o_onehot[o_idx] = o_found;
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: each requester may complete up to its
// weight in transactions per round; credits are refilled when every
// eligible requester has run dry.
module wrr_arbiter
  import wrr_pkg::*;
#(
  parameter  int N_REQ = WRR_N_REQ,
  parameter  int WW    = WRR_WW,
  parameter  int DEF_W = WRR_DEF_W,
  localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_REQ-1:0]          i_req,
  input  logic                      i_done,
  input  logic                      i_cfg_we,
  input  logic [N_REQ-1:0][WW-1:0]  i_cfg_weights,
  output logic [N_REQ-1:0]          o_gnt,
  output logic [IW-1:0]             o_gnt_id,
  output logic                      o_gnt_valid
);

  localparam logic [IW-1:0] LAST_ID = IW'(N_REQ - 1);
  localparam logic [WW-1:0] DEF_WV  = WW'(DEF_W);

  wrr_state_e               r_state;
  wrr_state_e               w_state_nxt;
  logic [N_REQ-1:0][WW-1:0] r_weight;
  logic [N_REQ-1:0][WW-1:0] r_credit;
  logic [IW-1:0]            r_last;
  logic [IW-1:0]            w_start;
  logic [N_REQ-1:0]         w_eligible;
  logic [N_REQ-1:0]         w_cand;
  logic [N_REQ-1:0]         w_pick_oh;
  logic [IW-1:0]            w_pick_id;
  logic                     w_pick_found;
  logic [N_REQ-1:0]         r_gnt;
  logic [N_REQ-1:0]         w_gnt_nxt;
  logic [IW-1:0]            r_gnt_id;
  logic [IW-1:0]            w_gnt_id_nxt;
  logic                     r_gnt_valid;

  // A zero weight masks a requester; a spent credit defers it to the next round.
  always_comb begin
    w_eligible = {N_REQ{1'b0}};
    w_cand     = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      w_eligible[i] = i_req[i] & (r_weight[i] != {WW{1'b0}});
      w_cand[i]     = w_eligible[i] & (r_credit[i] != {WW{1'b0}});
    end
  end

  assign w_start = (r_last == LAST_ID) ? {IW{1'b0}} : (r_last + IW'(1));

  rr_pick_first #(.N(N_REQ)) u_pick (
    .i_mask   (w_cand),
    .i_start  (w_start),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_id),
    .o_found  (w_pick_found)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic: grant if anyone has credit, refill if only credit is missing.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_pick_found)    w_state_nxt = GRANT;
        else if (|w_eligible) w_state_nxt = RELOAD;
        else                 w_state_nxt = IDLE;
      end
      GRANT: begin
        if (i_done) w_state_nxt = IDLE;
        else        w_state_nxt = GRANT;
      end
      RELOAD:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next grant value; the grant is held through GRANT until done, whatever req does.
  always_comb begin
    w_gnt_nxt    = r_gnt;
    w_gnt_id_nxt = r_gnt_id;
    case (r_state)
      IDLE: begin
        if (w_pick_found) begin
          w_gnt_nxt    = w_pick_oh;
          w_gnt_id_nxt = w_pick_id;
        end else begin
          w_gnt_nxt = {N_REQ{1'b0}};
        end
      end
      GRANT: begin
        if (i_done) w_gnt_nxt = {N_REQ{1'b0}};
        else        w_gnt_nxt = r_gnt;
      end
      RELOAD:  w_gnt_nxt = {N_REQ{1'b0}};
      default: w_gnt_nxt = {N_REQ{1'b0}};
    endcase
  end

  // Registered grant outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gnt       <= {N_REQ{1'b0}};
      r_gnt_id    <= {IW{1'b0}};
      r_gnt_valid <= 1'b0;
    end else begin
      r_gnt       <= w_gnt_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_gnt_valid <= |w_gnt_nxt;
    end
  end

  // Weights, credits and round-robin pointer; reset pointer makes requester 0 first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_weight <= {N_REQ{DEF_WV}};
      r_credit <= {N_REQ{DEF_WV}};
      r_last   <= LAST_ID;
    end else begin
      if (i_cfg_we) r_weight <= i_cfg_weights;
      if (r_state == RELOAD) begin
        r_credit <= i_cfg_we ? i_cfg_weights : r_weight;
      end else if ((r_state == GRANT) && i_done) begin
        if (r_credit[r_gnt_id] != {WW{1'b0}}) begin
          r_credit[r_gnt_id] <= r_credit[r_gnt_id] - WW'(1);
        end
        r_last <= r_gnt_id;
      end
    end
  end

  assign o_gnt       = r_gnt;
  assign o_gnt_id    = r_gnt_id;
  assign o_gnt_valid = r_gnt_valid;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed bench for wrr_arbiter: fixed sequences with hand-derived grant
// order and spacing between grants.
module tb_wrr_arbiter;
  import wrr_pkg::*;

  localparam int N  = 4;
  localparam int WW = 6;
  localparam int IW = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [N-1:0]         req;
  logic                 done;
  logic                 cfg_we;
  logic [N-1:0][WW-1:0] cfg_weights;
  logic [N-1:0]         gnt;
  logic [IW-1:0]        gnt_id;
  logic                 gnt_valid;

  int n_assert = 0;
  int n_fail   = 0;

  // Weights {1,2,3,4}: first round runs on reset credits of 1 each, then full rounds.
  int T2_ID  [15] = '{0, 1, 2, 3, 0, 1, 2, 3, 1, 2, 3, 2, 3, 3, 0};
  int T2_GAP [15] = '{1, 2, 2, 2, 4, 2, 2, 2, 2, 2, 2, 2, 2, 2, 4};
  // Default weights after reset, done held high: plain round robin, refill every 4.
  int T6_ID  [9]  = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
  int T6_GAP [9]  = '{1, 2, 2, 2, 4, 2, 2, 2, 4};

  always #5 clk = ~clk;

  wrr_arbiter dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_req         (req),
    .i_done        (done),
    .i_cfg_we      (cfg_we),
    .i_cfg_weights (cfg_weights),
    .o_gnt         (gnt),
    .o_gnt_id      (gnt_id),
    .o_gnt_valid   (gnt_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the next grant and checks its id, one-hot value and spacing.
  task automatic expect_grant(input string tag, input int exp_id, input int exp_gap);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!gnt_valid && cyc < 20);
    check({tag, "_valid"},  32'(gnt_valid), 32'd1);
    check({tag, "_id"},     32'(gnt_id),    exp_id);
    check({tag, "_gap"},    cyc,            exp_gap);
    check({tag, "_onehot"}, 32'(gnt),       32'd1 << exp_id);
  endtask

  initial begin
    int hits;
    int busy;
    req         = 4'b0000;
    done        = 1'b0;
    cfg_we      = 1'b0;
    cfg_weights = '0;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_gnt",   32'(gnt),       32'd0);
    check("rst_valid", 32'(gnt_valid), 32'd0);
    check("rst_id",    32'(gnt_id),    32'd0);
    @(negedge clk);
    @(negedge clk);

    // Test 1: default weights, done pulsed after each grant
    req   = 4'b1111;
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_first_gnt",   32'(gnt),       32'h1);
    check("t1_first_id",    32'(gnt_id),    32'd0);
    check("t1_first_valid", 32'(gnt_valid), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      done = 1'b1;
      @(negedge clk);
      check($sformatf("t1_clear_%0d", k), 32'(gnt), 32'd0);
      done = 1'b0;
      // after each fourth grant all credits are spent: refill adds 2 cycles
      expect_grant($sformatf("t1_g%0d", k), k % 4, (k % 4 == 0) ? 3 : 1);
    end

    // Test 2: weights {1,2,3,4}, done held high
    done  = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    @(negedge clk);
    rst_n       = 1'b1;
    cfg_we      = 1'b1;
    cfg_weights = {6'd4, 6'd3, 6'd2, 6'd1};
    @(negedge clk);
    cfg_we = 1'b0;
    req    = 4'b1111;
    done   = 1'b1;
    for (int j = 0; j < 15; j++) begin
      expect_grant($sformatf("t2_g%0d", j), T2_ID[j], T2_GAP[j]);
    end

    // Test 3: weight2 = 0 masks requester 2 and never triggers a refill
    req = 4'b0000;
    @(negedge clk);
    cfg_we      = 1'b1;
    cfg_weights = {6'd1, 6'd0, 6'd1, 6'd1};
    @(negedge clk);
    cfg_we = 1'b0;
    req    = 4'b0100;
    hits   = 0;
    busy   = 0;
    repeat (50) begin
      @(negedge clk);
      if (gnt_valid) hits++;
      if (dut.r_state != IDLE) busy++;
    end
    check("t3_masked_grants", hits, 32'd0);
    check("t3_not_idle",      busy, 32'd0);
    // requester 1 still holds credit 2 from the last round, then refills to 1
    req = 4'b0110;
    expect_grant("t3_g0", 1, 1);
    expect_grant("t3_g1", 1, 2);
    expect_grant("t3_g2", 1, 4);
    expect_grant("t3_g3", 1, 4);

    // Test 4: grant held with req dropped and done low
    done = 1'b0;
    req  = 4'b0000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("t4_hold_%0d", c), 32'(gnt), 32'h2);
    end
    done = 1'b1;
    @(negedge clk);
    check("t4_release_gnt",   32'(gnt),       32'd0);
    check("t4_release_valid", 32'(gnt_valid), 32'd0);
    done = 1'b0;

    // Test 5: asynchronous reset in the middle of a grant
    req = 4'b0001;
    expect_grant("t5_g0", 0, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_gnt",   32'(gnt),       32'd0);
    check("t5_async_valid", 32'(gnt_valid), 32'd0);
    check("t5_async_id",    32'(gnt_id),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0000;
    done  = 1'b1;

    // Test 6: stray done in IDLE, then done held high with all requesting
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("t6_stray_%0d", c), 32'(gnt_valid), 32'd0);
    end
    req = 4'b1111;
    for (int j = 0; j < 9; j++) begin
      expect_grant($sformatf("t6_g%0d", j), T6_ID[j], T6_GAP[j]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
